// File: rtl/seq_digit_sub.sv
// Digit-serial subtractor: a - b - bin, one DIGIT-wide slice per clock, LSB first.
// Optional second serial pass negates the result for absolute-difference mode.
module seq_digit_sub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bin,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(N - 1);

  typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [1:0]       mode_reg, mode_next;
  logic             borrow_reg, borrow_next;
  logic [SW-1:0]    step_reg, step_next;
  logic [WIDTH-1:0] diff_reg, diff_next;
  logic             out_borrow_reg, out_borrow_next;

  int               slice_lsb;
  logic [DIGIT-1:0] op_a, op_b;
  logic [DIGIT:0]   slice_full;
  logic             slice_bout;
  logic             mode_sat, mode_abs;

  // In NEG the same slice subtractor computes 0 - r[k] - borrow.
  assign slice_lsb  = int'(step_reg) * DIGIT;
  assign op_a       = (state_reg == NEG) ? '0 : a_reg[slice_lsb +: DIGIT];
  assign op_b       = (state_reg == NEG) ? diff_reg[slice_lsb +: DIGIT] : b_reg[slice_lsb +: DIGIT];
  assign slice_full = {1'b0, op_a} - {1'b0, op_b} - (DIGIT+1)'(borrow_reg);
  assign slice_bout = slice_full[DIGIT];

  assign mode_sat = (mode_reg == 2'b01);
  assign mode_abs = (mode_reg == 2'b10);

  always_comb begin
    state_next      = state_reg;
    a_next          = a_reg;
    b_next          = b_reg;
    mode_next       = mode_reg;
    borrow_next     = borrow_reg;
    step_next       = step_reg;
    diff_next       = diff_reg;
    out_borrow_next = out_borrow_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_next      = in_a;
          b_next      = in_b;
          mode_next   = in_mode;
          borrow_next = in_bin;
          step_next   = '0;
          state_next  = SUB;
        end
      end
      SUB: begin
        diff_next[slice_lsb +: DIGIT] = slice_full[DIGIT-1:0];
        borrow_next = slice_bout;
        step_next   = step_reg + SW'(1);
        if (step_reg == STEP_LAST) begin
          out_borrow_next = slice_bout;
          step_next       = '0;
          if (mode_abs && slice_bout) begin
            borrow_next = 1'b0;
            state_next  = NEG;
          end else begin
            state_next = DONE;
          end
          // Saturation overrides the final slice write in the same edge.
          if (mode_sat && slice_bout) begin
            diff_next = '0;
          end
        end
      end
      NEG: begin
        diff_next[slice_lsb +: DIGIT] = slice_full[DIGIT-1:0];
        borrow_next = slice_bout;
        step_next   = step_reg + SW'(1);
        if (step_reg == STEP_LAST) begin
          step_next  = '0;
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      a_reg          <= '0;
      b_reg          <= '0;
      mode_reg       <= 2'b00;
      borrow_reg     <= 1'b0;
      step_reg       <= '0;
      diff_reg       <= '0;
      out_borrow_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      a_reg          <= a_next;
      b_reg          <= b_next;
      mode_reg       <= mode_next;
      borrow_reg     <= borrow_next;
      step_reg       <= step_next;
      diff_reg       <= diff_next;
      out_borrow_reg <= out_borrow_next;
    end
  end

  assign in_ready   = (state_reg == IDLE) && !rst;
  assign out_valid  = (state_reg == DONE);
  assign busy       = (state_reg == SUB) || (state_reg == NEG);
  assign out_diff   = diff_reg;
  assign out_borrow = out_borrow_reg;

endmodule

// File: tb/tb_seq_digit_sub.sv
// Self-checking bench for seq_digit_sub (WIDTH=32, DIGIT=4): directed cases, random
// operands against an arithmetic model, backpressure, mid-operation reset, throughput.
module tb_seq_digit_sub;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        in_bin;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_diff;
  logic        out_borrow;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  seq_digit_sub #(.WIDTH(32), .DIGIT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_bin(in_bin), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_borrow(out_borrow), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [1:0]  mode;
    logic [31:0] d;
    logic        bo;
    int          lat;
  } vec_t;

  // Reference: plain wide arithmetic on the whole operands.
  task automatic model(input logic [31:0] a, b, input logic bin, input logic [1:0] mode,
                       output logic [31:0] d, output logic bo, output int lat);
    logic [33:0] need;
    logic [31:0] wrap;
    need = {2'b00, b} + {33'd0, bin};
    bo   = ({2'b00, a} < need);
    wrap = a - b - {31'd0, bin};
    case (mode)
      2'b01:   d = bo ? 32'd0 : wrap;
      2'b10:   d = bo ? 32'(need - {2'b00, a}) : wrap;
      default: d = wrap;
    endcase
    lat = (mode == 2'b10 && bo) ? 2 * N : N;
  endtask

  // Drives one operation; returns after the result handshake, #1 past that edge.
  task automatic do_op(input logic [31:0] a, b, input logic bin, input logic [1:0] mode,
                       input int hold, output logic [31:0] d, output logic bo,
                       output int lat, output int acc_cyc, output logic to, output logic held_ok);
    int w;
    to = 1'b0; held_ok = 1'b1; d = '0; bo = 1'b0; lat = 0; acc_cyc = 0; w = 0;
    in_a = a; in_b = b; in_bin = bin; in_mode = mode; in_valid = 1'b1;
    out_ready = (hold == 0);
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) begin
      to = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      return;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_bin = 1'($urandom); in_mode = 2'($urandom);
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) begin
      to = 1'b1; out_ready = 1'b1;
      return;
    end
    d = out_diff; bo = out_borrow;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      if (!out_valid || out_diff !== d || out_borrow !== bo || in_ready || busy) held_ok = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    $display("op a=%h b=%h bin=%0d mode=%0d -> diff=%h borrow=%0d lat=%0d", a, b, bin, mode, d, bo, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got valid=%b busy=%b ready=%b want 0 0 0", out_valid, busy, in_ready);
    end
    checks++;
    if (out_diff !== 32'd0 || out_borrow !== 1'b0) begin
      errors++;
      $display("FAIL reset_data got diff=%h borrow=%b want 0 0", out_diff, out_borrow);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    vec_t dv[9];
    logic [31:0] d; logic bo, to, hok; int lat, acc;
    dv[0] = '{32'h0000_1234, 32'h0000_0234, 1'b0, 2'b00, 32'h0000_1000, 1'b0, 8};
    dv[1] = '{32'd5,         32'd7,         1'b0, 2'b00, 32'hFFFF_FFFE, 1'b1, 8};
    dv[2] = '{32'h8000_0000, 32'd0,         1'b1, 2'b00, 32'h7FFF_FFFF, 1'b0, 8};
    dv[3] = '{32'd5,         32'd7,         1'b0, 2'b01, 32'd0,         1'b1, 8};
    dv[4] = '{32'd7,         32'd5,         1'b1, 2'b01, 32'd1,         1'b0, 8};
    dv[5] = '{32'd5,         32'd7,         1'b0, 2'b10, 32'd2,         1'b1, 16};
    dv[6] = '{32'd0,         32'hFFFF_FFFF, 1'b1, 2'b10, 32'd0,         1'b1, 16};
    dv[7] = '{32'd5,         32'd7,         1'b0, 2'b11, 32'hFFFF_FFFE, 1'b1, 8};
    dv[8] = '{32'd7,         32'd5,         1'b0, 2'b10, 32'd2,         1'b0, 8};
    for (int i = 0; i < 9; i++) begin
      do_op(dv[i].a, dv[i].b, dv[i].bin, dv[i].mode, 0, d, bo, lat, acc, to, hok);
      checks++;
      if (to !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_timeout got timeout=%b want 0", i, to);
      end
      checks++;
      if (d !== dv[i].d || bo !== dv[i].bo) begin
        errors++;
        $display("FAIL dir%0d_result got diff=%h borrow=%b want diff=%h borrow=%b", i, d, bo, dv[i].d, dv[i].bo);
      end
      checks++;
      if (lat !== dv[i].lat) begin
        errors++;
        $display("FAIL dir%0d_latency got %0d want %0d", i, lat, dv[i].lat);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, d, ed; logic bin, bo, ebo, to, hok; logic [1:0] mode; int lat, elat, acc;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom; bin = 1'($urandom); mode = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: b = a;
        1: begin a = $urandom_range(0, 15); b = $urandom_range(0, 15); end
        default: ;
      endcase
      model(a, b, bin, mode, ed, ebo, elat);
      do_op(a, b, bin, mode, 0, d, bo, lat, acc, to, hok);
      checks++;
      if (to !== 1'b0 || d !== ed || bo !== ebo || lat !== elat) begin
        errors++;
        $display("FAIL rnd%0d got diff=%h borrow=%b lat=%0d to=%b want diff=%h borrow=%b lat=%0d to=0",
                 i, d, bo, lat, to, ed, ebo, elat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d, d2, ed; logic bo, bo2, ebo, to, to2, hok, hok2; int lat, lat2, acc, acc2, elat;
    do_op(32'd100, 32'd300, 1'b0, 2'b10, 5, d, bo, lat, acc, to, hok);
    checks++;
    if (to !== 1'b0 || hok !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold got timeout=%b stable=%b want 0 1", to, hok);
    end
    checks++;
    if (d !== 32'd200 || bo !== 1'b1) begin
      errors++;
      $display("FAIL bp_result got diff=%h borrow=%b want %h 1", d, bo, 32'd200);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_after got %b want 1", in_ready);
    end
    model(32'h0000_ABCD, 32'h0000_0BCD, 1'b1, 2'b00, ed, ebo, elat);
    do_op(32'h0000_ABCD, 32'h0000_0BCD, 1'b1, 2'b00, 0, d2, bo2, lat2, acc2, to2, hok2);
    checks++;
    if (acc2 - acc !== lat + 5 + 2 || d2 !== ed || bo2 !== ebo) begin
      errors++;
      $display("FAIL bp_next_op got gap=%0d diff=%h borrow=%b want gap=%0d diff=%h borrow=%b",
               acc2 - acc, d2, bo2, lat + 7, ed, ebo);
    end
  endtask

  task automatic test_reset_mid();
    logic seen; logic [31:0] d; logic bo, to, hok; int lat, acc;
    in_a = 32'h1234_5678; in_b = 32'h0000_1111; in_bin = 1'b0; in_mode = 2'b00;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_diff !== 32'd0 || out_borrow !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state got valid=%b busy=%b diff=%h borrow=%b want 0 0 0 0",
               out_valid, busy, out_diff, out_borrow);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready got %b want 1", in_ready);
    end
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_result got out_valid seen=%b want 0", seen);
    end
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 2'b00, 0, d, bo, lat, acc, to, hok);
    checks++;
    if (to !== 1'b0 || d !== 32'hFFFF_FFFE || bo !== 1'b0) begin
      errors++;
      $display("FAIL midrst_follow got diff=%h borrow=%b to=%b want fffffffe 0 0", d, bo, to);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic bo, to, hok; int lat, acc, prev_acc, prev_lat;
    do_op(32'd9, 32'd3, 1'b0, 2'b10, 0, d, bo, prev_lat, prev_acc, to, hok);
    do_op(32'd3, 32'd9, 1'b0, 2'b10, 0, d, bo, lat, acc, to, hok);
    checks++;
    if (acc - prev_acc !== N + 2) begin
      errors++;
      $display("FAIL b2b_gap1 got %0d want %0d", acc - prev_acc, N + 2);
    end
    prev_acc = acc;
    do_op(32'd1, 32'd1, 1'b0, 2'b01, 0, d, bo, prev_lat, acc, to, hok);
    checks++;
    if (acc - prev_acc !== 2 * N + 2 || d !== 32'd0 || bo !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap2 got gap=%0d diff=%h borrow=%b want gap=%0d diff=0 borrow=0",
               acc - prev_acc, d, bo, 2 * N + 2);
    end
  endtask

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; in_bin = 1'b0; in_mode = 2'b00; out_ready = 1'b1;
    rst = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
